wb_input_port: RTL and testbench

WB_INPUT_PORT -- requirements
Module: wb_input_port

---
 rtl/wb_input_port_pkg.sv | 34 +++
 rtl/wb_input_port_sync_fifo.sv | 57 +++++
 rtl/wb_input_port.sv | 114 +++++++++++
 tb/tb_wb_input_port.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_input_port_pkg.sv
// Shared register map for the Wishbone input port.
// The cpu test software uses the same offsets and bit positions.
//   reg_addr_e         : register selected by adr[3:2]
//   STATUS_* / CONTROL_*: bit positions inside STATUS and CONTROL
//   status_word()      : packs FIFO flags and occupancy into a STATUS read value
package wb_input_port_pkg;

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_STATUS   = 2'd1,
        REG_CONTROL  = 2'd2,
        REG_RESERVED = 2'd3
    } reg_addr_e;

    localparam int STATUS_EMPTY_BIT   = 0;
    localparam int STATUS_FULL_BIT    = 1;
    localparam int STATUS_COUNT_LSB   = 4;
    localparam int STATUS_COUNT_W     = 5;
    localparam int CONTROL_IRQ_EN_BIT = 0;

    function automatic logic [31:0] status_word(
        input logic                      empty,
        input logic                      full,
        input logic [STATUS_COUNT_W-1:0] count
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_EMPTY_BIT] = empty;
        s[STATUS_FULL_BIT]  = full;
        s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
        return s;
    endfunction

endpackage

// File: rtl/wb_input_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears pointers/count)
//   push      : write wdata this edge (ignored when full)
//   pop       : drop head word this edge (ignored when empty)
//   wdata     : word to write
//   full/empty: flags from registered count
//   count     : occupancy, 0..DEPTH
//   head      : oldest word, valid while !empty
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_input_port.sv
// wb_input_port: Wishbone classic slave in front of a word FIFO filled by an
// external producer. The cpu drains the FIFO through DATA reads and can get
// a level interrupt while words are waiting.
// Ports:
//   clock_i, reset_i      : clock, synchronous active-high reset
//   adr_i .. bte_i        : Wishbone slave inputs (adr_i[3:2] decoded, cti/bte ignored)
//   dat_o, ack_o          : Wishbone read data and acknowledge (registered)
//   in_data_i, in_valid_i : producer word and valid
//   in_ready_o            : FIFO can take a word this cycle
//   interrupt_request_o   : irq_enable & FIFO non-empty (registered)
module wb_input_port
    import wb_input_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [2:0]  cti_i,
    input  logic [1:0]  bte_i,
    output logic        ack_o,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        interrupt_request_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;
    logic [CW-1:0] count_next;

    logic          irq_enable;
    logic          irq_enable_next;
    reg_addr_e     reg_sel;
    logic          req;
    logic          push;
    logic          pop;
    logic          ctrl_wr;
    logic [31:0]   rd_data;
    logic          unused_inputs;

    assign reg_sel = reg_addr_e'(adr_i[3:2]);

    // A request still showing during its own ack cycle is not a new one.
    assign req = cyc_i & stb_i & ~ack_o;

    // Held low during reset so the producer never sees a ready it can't use.
    assign in_ready_o = ~fifo_full & ~reset_i;

    assign push    = in_valid_i & in_ready_o;
    assign pop     = req & ~we_i & (reg_sel == REG_DATA) & ~fifo_empty;
    assign ctrl_wr = req & we_i & (reg_sel == REG_CONTROL) & sel_i[0];

    assign irq_enable_next = ctrl_wr ? dat_i[CONTROL_IRQ_EN_BIT] : irq_enable;

    // Occupancy after this edge, so the interrupt tracks the updated FIFO
    // rather than lagging it by a cycle.
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA:     rd_data = fifo_empty ? 32'h0 : fifo_head;
            REG_STATUS:   rd_data = status_word(fifo_empty, fifo_full,
                                                STATUS_COUNT_W'(fifo_count));
            REG_CONTROL:  rd_data[CONTROL_IRQ_EN_BIT] = irq_enable;
            REG_RESERVED: rd_data = '0;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ack_o               <= 1'b0;
            dat_o               <= '0;
            irq_enable          <= 1'b0;
            interrupt_request_o <= 1'b0;
        end else begin
            ack_o               <= req;
            dat_o               <= (req & ~we_i) ? rd_data : 32'h0;
            irq_enable          <= irq_enable_next;
            interrupt_request_o <= irq_enable_next & (count_next != '0);
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clock_i),
        .rst   (reset_i),
        .push  (push),
        .pop   (pop),
        .wdata (in_data_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign unused_inputs = ^{adr_i[31:4], adr_i[1:0], dat_i[31:1],
                             sel_i[3:1], cti_i, bte_i};

endmodule

// File: tb/tb_wb_input_port.sv
module tb_wb_input_port;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        stb_i;
    logic        cyc_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic        ack_o;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        interrupt_request_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock_i = ~clock_i;

    wb_input_port #(.DEPTH(4)) dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .adr_i               (adr_i),
        .dat_i               (dat_i),
        .dat_o               (dat_o),
        .stb_i               (stb_i),
        .cyc_i               (cyc_i),
        .we_i                (we_i),
        .sel_i               (sel_i),
        .cti_i               (cti_i),
        .bte_i               (bte_i),
        .ack_o               (ack_o),
        .in_data_i           (in_data_i),
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .interrupt_request_o (interrupt_request_o)
    );

    typedef enum {OP_PUSH, OP_RD, OP_WR} op_e;

    typedef struct {
        op_e         op;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t vt[$];

    task automatic add(input op_e op, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp, input logic exp_irq);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.s = s; v.exp = exp; v.exp_irq = exp_irq;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic bus_issue(input logic we, input logic [1:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
        adr_i = {28'h0, a, 2'b00}; dat_i = d; sel_i = s;
        tick();
    endtask

    task automatic bus_finish(input string name, input logic we, input logic [31:0] exp);
        check({name, " ack"}, 32'(ack_o), 32'd1);
        if (!we) check({name, " dat"}, dat_o, exp);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tick();
        check({name, " ack drop"}, 32'(ack_o), 32'd0);
        check({name, " dat idle"}, dat_o, 32'd0);
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_issue(1'b0, a, 32'h0, 4'h0);
        bus_finish(name, 1'b0, exp);
    endtask

    task automatic wr(input string name, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        bus_issue(1'b1, a, d, s);
        bus_finish(name, 1'b1, 32'h0);
    endtask

    task automatic push(input logic [31:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; adr_i = '0; dat_i = '0; stb_i = 1'b0; cyc_i = 1'b0;
        we_i = 1'b0; sel_i = '0; cti_i = '0; bte_i = '0;
        in_data_i = '0; in_valid_i = 1'b0;

        // Reset state
        tick();
        check("rst ready", 32'(in_ready_o), 32'd0);
        check("rst ack", 32'(ack_o), 32'd0);
        check("rst dat", dat_o, 32'd0);
        check("rst irq", 32'(interrupt_request_o), 32'd0);
        tick();
        reset_i = 1'b0;
        #1;
        check("post-rst ready", 32'(in_ready_o), 32'd1);
        rd("rst status", 2'd1, 32'h00000001);
        rd("rst control", 2'd2, 32'h00000000);

        // Table: register map, ordering, empty read, irq enable/masking
        add(OP_PUSH, 2'd0, 32'h11111111, 4'h0, 32'h0, 1'b0);
        add(OP_PUSH, 2'd0, 32'h22222222, 4'h0, 32'h0, 1'b0);
        add(OP_RD,   2'd1, 32'h0,        4'h0, 32'h00000020, 1'b0);
        add(OP_RD,   2'd0, 32'h0,        4'h0, 32'h11111111, 1'b0);
        add(OP_RD,   2'd0, 32'h0,        4'h0, 32'h22222222, 1'b0);
        add(OP_RD,   2'd0, 32'h0,        4'h0, 32'h00000000, 1'b0);
        add(OP_RD,   2'd1, 32'h0,        4'h0, 32'h00000001, 1'b0);
        add(OP_WR,   2'd2, 32'h1,        4'h1, 32'h0, 1'b0);
        add(OP_RD,   2'd2, 32'h0,        4'h0, 32'h00000001, 1'b0);
        add(OP_PUSH, 2'd0, 32'hA5A5A5A5, 4'h0, 32'h0, 1'b1);
        add(OP_RD,   2'd1, 32'h0,        4'h0, 32'h00000010, 1'b1);
        add(OP_RD,   2'd0, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0);
        add(OP_WR,   2'd2, 32'h0,        4'h1, 32'h0, 1'b0);
        add(OP_WR,   2'd2, 32'h1,        4'h0, 32'h0, 1'b0);
        add(OP_RD,   2'd2, 32'h0,        4'h0, 32'h00000000, 1'b0);
        add(OP_PUSH, 2'd0, 32'h33333333, 4'h0, 32'h0, 1'b0);
        add(OP_WR,   2'd0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        add(OP_WR,   2'd1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
        add(OP_WR,   2'd3, 32'h12345678, 4'hF, 32'h0, 1'b0);
        add(OP_RD,   2'd3, 32'h0,        4'h0, 32'h00000000, 1'b0);
        add(OP_RD,   2'd1, 32'h0,        4'h0, 32'h00000010, 1'b0);
        add(OP_WR,   2'd2, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        add(OP_RD,   2'd2, 32'h0,        4'h0, 32'h00000001, 1'b1);
        add(OP_WR,   2'd2, 32'h0,        4'h1, 32'h0, 1'b0);
        add(OP_RD,   2'd0, 32'h0,        4'h0, 32'h33333333, 1'b0);
        add(OP_RD,   2'd1, 32'h0,        4'h0, 32'h00000001, 1'b0);

        foreach (vt[i]) begin
            string nm;
            nm = $sformatf("v%0d", i);
            case (vt[i].op)
                OP_PUSH: begin
                    push(vt[i].d);
                    check({nm, " ready"}, 32'(in_ready_o), 32'd1);
                end
                OP_RD:   rd(nm, vt[i].a, vt[i].exp);
                default: wr(nm, vt[i].a, vt[i].d, vt[i].s);
            endcase
            check({nm, " irq"}, 32'(interrupt_request_o), 32'(vt[i].exp_irq));
        end

        // Fill to full with in_valid held; fifth word waits for a DATA read
        do_reset();
        in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = 32'hF000_0000 + 32'(i);
            tick();
        end
        in_data_i = 32'hF000_0004;
        check("full ready", 32'(in_ready_o), 32'd0);
        tick();
        tick();
        check("full ready held", 32'(in_ready_o), 32'd0);
        rd("full status", 2'd1, 32'h00000042);
        rd("full pop0", 2'd0, 32'hF000_0000);
        in_valid_i = 1'b0;
        rd("refill status", 2'd1, 32'h00000042);
        for (int i = 1; i < 5; i++)
            rd($sformatf("drain%0d", i), 2'd0, 32'hF000_0000 + 32'(i));
        rd("drained status", 2'd1, 32'h00000001);

        // Push and pop on the same edge at count 2
        push(32'hB0000001);
        push(32'hB0000002);
        in_valid_i = 1'b1;
        in_data_i  = 32'hB0000003;
        bus_issue(1'b0, 2'd0, 32'h0, 4'h0);
        in_valid_i = 1'b0;
        bus_finish("simul pop", 1'b0, 32'hB0000001);
        rd("simul status", 2'd1, 32'h00000020);
        rd("simul b2", 2'd0, 32'hB0000002);
        rd("simul b3", 2'd0, 32'hB0000003);

        // Request held through its ack cycle: one ack, one pop
        push(32'hC0000001);
        push(32'hC0000002);
        bus_issue(1'b0, 2'd0, 32'h0, 4'h0);
        check("held ack", 32'(ack_o), 32'd1);
        check("held dat", dat_o, 32'hC0000001);
        tick();
        check("held ack low", 32'(ack_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
        rd("held status", 2'd1, 32'h00000010);
        rd("held c2", 2'd0, 32'hC0000002);

        // Reset during a pending DATA read with 3 words queued
        wr("rst-mid ctrl", 2'd2, 32'h1, 4'h1);
        push(32'hD0000001);
        push(32'hD0000002);
        push(32'hD0000003);
        check("rst-mid irq before", 32'(interrupt_request_o), 32'd1);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0;
        reset_i = 1'b1;
        tick();
        check("rst-mid ack", 32'(ack_o), 32'd0);
        check("rst-mid dat", dat_o, 32'd0);
        check("rst-mid irq", 32'(interrupt_request_o), 32'd0);
        check("rst-mid ready", 32'(in_ready_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        reset_i = 1'b0;
        tick();
        check("rst-mid ack after", 32'(ack_o), 32'd0);
        rd("rst-mid status", 2'd1, 32'h00000001);
        rd("rst-mid control", 2'd2, 32'h00000000);
        check("rst-mid irq after", 32'(interrupt_request_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
